// File: rtl/jacobi_row_pair_ctrl.sv
// jacobi_row_pair_ctrl
//   Sequencer that sits in front of the row RAM wrapper for one Jacobi sweep step. It reads
//   row p and then row q through the wrapper's two-port muxed interface, and hands both rows
//   to the rotation unit. It then accepts the rotated rows and writes them back, p first and
//   then q. This block is the only master of the wrapper's ena/read_write/mux controls.
//
// Optional feature (macro JACOBI_PAIR_CHECK_EN):
//   When the macro is defined, a start with p_idx == q_idx is refused. The block makes no RAM
//   access and does not raise busy. Instead it pulses pair_err for one cycle. When the macro
//   is undefined, pair_err does not exist and equal indices run the full sequence, so q is
//   written last and q's data is what stays in the row.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   start, p_idx, q_idx        operation request; sampled only in idle
//   busy, done                 status; done is a 1-cycle pulse after q is written back
//   rows_valid/rows_ready      row_p/row_q handshake towards the rotation unit
//   rot_valid/rot_ready        rot_p/rot_q handshake from the rotation unit
//   ram_*                      wrapper controls, addresses, write data, read data
//   pair_err                   (JACOBI_PAIR_CHECK_EN only) equal-index start refused
//
// Every output comes from a register. Control outputs are decoded from the next state, so
// each output lines up with the state it belongs to.

module jacobi_row_pair_ctrl #(
    parameter int unsigned ROW_W    = 1024,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] p_idx,
    input  logic [ADDR_W-1:0] q_idx,
    output logic              busy,
    output logic              done,
    output logic              rows_valid,
    input  logic              rows_ready,
    output logic [ROW_W-1:0]  row_p,
    output logic [ROW_W-1:0]  row_q,
    input  logic              rot_valid,
    output logic              rot_ready,
    input  logic [ROW_W-1:0]  rot_p,
    input  logic [ROW_W-1:0]  rot_q,
    output logic              ram_ena,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_address_1,
    output logic [ADDR_W-1:0] ram_address_2,
    output logic [ROW_W-1:0]  ram_data_in_1,
    output logic [ROW_W-1:0]  ram_data_in_2,
    output logic              ram_address_mux,
    output logic              ram_data_in_mux,
    output logic              ram_data_out_mux,
`ifdef JACOBI_PAIR_CHECK_EN
    output logic              pair_err,
`endif
    input  logic [ROW_W-1:0]  ram_data_out_1,
    input  logic [ROW_W-1:0]  ram_data_out_2
);

    localparam int unsigned CntW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StRdP,
        StWtP,
        StRdQ,
        StWtQ,
        StPresent,
        StWaitRot,
        StWrP,
        StWrQ,
        StDone
    } state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic              wait_last;
    logic              accept_start;
    logic              rot_fire;

    logic              busy_d, done_d, rows_valid_d, rot_ready_d;
    logic              ram_ena_d, ram_rw_d;
    logic              addr_mux_d, din_mux_d, dout_mux_d;
`ifdef JACOBI_PAIR_CHECK_EN
    logic              pair_err_d;
`endif

    assign wait_last    = (wait_cnt_q == CntW'(READ_LAT - 1));
    assign accept_start = (state_q == StIdle) && (state_d == StRdP);
    assign rot_fire     = (state_q == StWaitRot) && rot_valid && rot_ready;

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
`ifdef JACOBI_PAIR_CHECK_EN
        pair_err_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
`ifdef JACOBI_PAIR_CHECK_EN
                    if (p_idx == q_idx) begin
                        pair_err_d = 1'b1;
                    end else begin
                        state_d = StRdP;
                    end
`else
                    state_d = StRdP;
`endif
                end
            end
            StRdP: begin
                state_d    = StWtP;
                wait_cnt_d = '0;
            end
            StWtP: begin
                if (wait_last) begin
                    state_d = StRdQ;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StRdQ: begin
                state_d    = StWtQ;
                wait_cnt_d = '0;
            end
            StWtQ: begin
                if (wait_last) begin
                    state_d = StPresent;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StPresent: begin
                if (rows_valid && rows_ready) begin
                    state_d = StWaitRot;
                end
            end
            StWaitRot: begin
                if (rot_valid && rot_ready) begin
                    state_d = StWrP;
                end
            end
            StWrP:   state_d = StWrQ;
            StWrQ:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the next state; the values are registered below.
    always_comb begin
        ram_ena_d    = (state_d == StRdP) || (state_d == StRdQ) ||
                       (state_d == StWrP) || (state_d == StWrQ);
        ram_rw_d     = (state_d == StWrP) || (state_d == StWrQ);
        // Each mux select is held through the wait states that follow its access.
        addr_mux_d   = (state_d == StRdQ) || (state_d == StWtQ) || (state_d == StWrQ);
        dout_mux_d   = (state_d == StRdQ) || (state_d == StWtQ);
        din_mux_d    = (state_d == StWrQ);
        busy_d       = (state_d != StIdle) && (state_d != StDone);
        done_d       = (state_d == StDone);
        rows_valid_d = (state_d == StPresent);
        rot_ready_d  = (state_d == StWaitRot);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            wait_cnt_q       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            rows_valid       <= 1'b0;
            rot_ready        <= 1'b0;
            row_p            <= '0;
            row_q            <= '0;
            ram_ena          <= 1'b0;
            ram_rw           <= 1'b0;
            ram_address_1    <= '0;
            ram_address_2    <= '0;
            ram_data_in_1    <= '0;
            ram_data_in_2    <= '0;
            ram_address_mux  <= 1'b0;
            ram_data_in_mux  <= 1'b0;
            ram_data_out_mux <= 1'b0;
`ifdef JACOBI_PAIR_CHECK_EN
            pair_err         <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            wait_cnt_q       <= wait_cnt_d;
            busy             <= busy_d;
            done             <= done_d;
            rows_valid       <= rows_valid_d;
            rot_ready        <= rot_ready_d;
            ram_ena          <= ram_ena_d;
            ram_rw           <= ram_rw_d;
            ram_address_mux  <= addr_mux_d;
            ram_data_in_mux  <= din_mux_d;
            ram_data_out_mux <= dout_mux_d;
`ifdef JACOBI_PAIR_CHECK_EN
            pair_err         <= pair_err_d;
`endif
            if (accept_start) begin
                ram_address_1 <= p_idx;
                ram_address_2 <= q_idx;
            end
            // Read data appears READ_LAT cycles after the access; capture it on the last wait.
            if (state_q == StWtP && wait_last) begin
                row_p <= ram_data_out_1;
            end
            if (state_q == StWtQ && wait_last) begin
                row_q <= ram_data_out_2;
            end
            if (rot_fire) begin
                ram_data_in_1 <= rot_p;
                ram_data_in_2 <= rot_q;
            end
        end
    end

endmodule

// File: tb/tb_jacobi_row_pair_ctrl.sv
module tb_jacobi_row_pair_ctrl;

    localparam int ROW_W  = 1024;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] p_idx = '0, q_idx = '0;
    logic              busy, done, rows_valid, rot_ready;
    logic              rows_ready = 1'b0, rot_valid = 1'b0;
    logic [ROW_W-1:0]  row_p, row_q;
    logic [ROW_W-1:0]  rot_p = '0, rot_q = '0;
    logic              ram_ena, ram_rw, ram_address_mux, ram_data_in_mux, ram_data_out_mux;
    logic [ADDR_W-1:0] ram_address_1, ram_address_2;
    logic [ROW_W-1:0]  ram_data_in_1, ram_data_in_2;
    logic [ROW_W-1:0]  ram_data_out_1 = '0, ram_data_out_2 = '0;
`ifdef JACOBI_PAIR_CHECK_EN
    logic              pair_err;
`endif

    jacobi_row_pair_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .p_idx            (p_idx),
        .q_idx            (q_idx),
        .busy             (busy),
        .done             (done),
        .rows_valid       (rows_valid),
        .rows_ready       (rows_ready),
        .row_p            (row_p),
        .row_q            (row_q),
        .rot_valid        (rot_valid),
        .rot_ready        (rot_ready),
        .rot_p            (rot_p),
        .rot_q            (rot_q),
        .ram_ena          (ram_ena),
        .ram_rw           (ram_rw),
        .ram_address_1    (ram_address_1),
        .ram_address_2    (ram_address_2),
        .ram_data_in_1    (ram_data_in_1),
        .ram_data_in_2    (ram_data_in_2),
        .ram_address_mux  (ram_address_mux),
        .ram_data_in_mux  (ram_data_in_mux),
        .ram_data_out_mux (ram_data_out_mux),
`ifdef JACOBI_PAIR_CHECK_EN
        .pair_err         (pair_err),
`endif
        .ram_data_out_1   (ram_data_out_1),
        .ram_data_out_2   (ram_data_out_2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Row RAM wrapper model: one access per enabled cycle, read latency 1.
    logic [ROW_W-1:0]  mem [32];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [ROW_W-1:0]  pre_data = '0;
    logic [ADDR_W-1:0] eff_addr;
    logic [ROW_W-1:0]  eff_din;
    assign eff_addr = ram_address_mux ? ram_address_2 : ram_address_1;
    assign eff_din  = ram_data_in_mux ? ram_data_in_2 : ram_data_in_1;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_ena) begin
            if (ram_rw) mem[eff_addr] <= eff_din;
            else if (ram_data_out_mux) ram_data_out_2 <= mem[eff_addr];
            else ram_data_out_1 <= mem[eff_addr];
        end
    end

    typedef struct {logic [ADDR_W-1:0] addr; int cyc;} rd_t;
    typedef struct {logic [ROW_W-1:0] p; logic [ROW_W-1:0] q; int cyc;} rows_t;
    typedef struct {logic [ADDR_W-1:0] addr; logic [ROW_W-1:0] data; int cyc;} wr_t;
    rd_t   rd_q[$];
    rows_t rows_q[$];
    wr_t   wr_q[$];
    int    done_q[$];
    int    err_q[$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_row(input string name, input logic [ROW_W-1:0] got,
                           input logic [ROW_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got ..%016h expected ..%016h (cycle %0d)", name, got[63:0],
                     exp[63:0], cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a transaction.
    always @(negedge clk) begin
        rd_t e_rd;
        rows_t e_rows;
        wr_t e_wr;
        int e_c;
        if (!reset) begin
            if (ram_ena && !ram_rw) begin
                chk("read expected", 64'(rd_q.size() != 0), 64'd1);
                if (rd_q.size() != 0) begin
                    e_rd = rd_q.pop_front();
                    chk("read addr", 64'(eff_addr), 64'(e_rd.addr));
                    chk("read cycle", 64'(cyc), 64'(e_rd.cyc));
                end
            end
            if (ram_ena && ram_rw) begin
                chk("write expected", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0) begin
                    e_wr = wr_q.pop_front();
                    chk("write addr", 64'(eff_addr), 64'(e_wr.addr));
                    chk_row("write data", eff_din, e_wr.data);
                    chk("write cycle", 64'(cyc), 64'(e_wr.cyc));
                end
            end
            if (rows_valid && rows_ready) begin
                chk("rows expected", 64'(rows_q.size() != 0), 64'd1);
                if (rows_q.size() != 0) begin
                    e_rows = rows_q.pop_front();
                    chk_row("row_p", row_p, e_rows.p);
                    chk_row("row_q", row_q, e_rows.q);
                    chk("rows cycle", 64'(cyc), 64'(e_rows.cyc));
                end
            end
            if (done) begin
                chk("done expected", 64'(done_q.size() != 0), 64'd1);
                chk("busy at done", 64'(busy), 64'd0);
                if (done_q.size() != 0) begin
                    e_c = done_q.pop_front();
                    chk("done cycle", 64'(cyc), 64'(e_c));
                end
            end
`ifdef JACOBI_PAIR_CHECK_EN
            if (pair_err) begin
                chk("pair_err expected", 64'(err_q.size() != 0), 64'd1);
                if (err_q.size() != 0) begin
                    e_c = err_q.pop_front();
                    chk("pair_err cycle", 64'(cyc), 64'(e_c));
                end
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ROW_W-1:0] mk(input logic [31:0] seed);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < ROW_W / 64; i++) r[i*64 +: 64] = {seed, 32'(i) ^ 32'h5a5a_0000};
        return r;
    endfunction

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [ROW_W-1:0] d);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " rows_valid"}, 64'(rows_valid), 64'd0);
        chk({tag, " rot_ready"}, 64'(rot_ready), 64'd0);
        chk({tag, " ram ctrl"}, 64'({ram_ena, ram_rw, ram_address_mux, ram_data_in_mux,
                                     ram_data_out_mux}), 64'd0);
        chk({tag, " ram addr"}, 64'({ram_address_1, ram_address_2}), 64'd0);
        chk_row({tag, " row_p"}, row_p, '0);
        chk_row({tag, " row_q"}, row_q, '0);
        chk_row({tag, " data_in_1"}, ram_data_in_1, '0);
    endtask

    // One pair operation. hold: cycles rows_ready stays low once rows_valid is up.
    // rot_dly: cycles in WAIT_ROT before rot_valid. poke: pulse start while busy.
    task automatic run_op(input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] q,
                          input logic [ROW_W-1:0] ep, input logic [ROW_W-1:0] eq,
                          input logic [ROW_W-1:0] rp, input logic [ROW_W-1:0] rq,
                          input int hold, input int rot_dly, input bit poke);
        int c0, w;
        rd_t r;
        rows_t rw;
        wr_t wv;
        c0 = cyc;
        r.addr = p; r.cyc = c0 + 1; rd_q.push_back(r);
        r.addr = q; r.cyc = c0 + 3; rd_q.push_back(r);
        rw.p = ep; rw.q = eq; rw.cyc = c0 + 5 + hold; rows_q.push_back(rw);
        rows_ready = (hold == 0);
        p_idx = p; q_idx = q; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy after start", 64'(busy), 64'd1);
        repeat (4) tick();
        for (int i = 0; i < hold; i++) begin
            chk("hold rows_valid", 64'(rows_valid), 64'd1);
            chk_row("hold row_p", row_p, ep);
            chk_row("hold row_q", row_q, eq);
            chk("hold ram_ena", 64'(ram_ena), 64'd0);
            start = poke && (i == 1);
            tick();
            start = 1'b0;
        end
        rows_ready = 1'b1;
        tick();
        rows_ready = 1'b0;
        for (int i = 0; i < rot_dly; i++) begin
            chk("wait rot_ready", 64'(rot_ready), 64'd1);
            start = poke && (i == 0);
            tick();
            start = 1'b0;
        end
        chk("rot_ready", 64'(rot_ready), 64'd1);
        rot_valid = 1'b1; rot_p = rp; rot_q = rq;
        w = cyc;
        wv.addr = p; wv.data = rp; wv.cyc = w + 1; wr_q.push_back(wv);
        wv.addr = q; wv.data = rq; wv.cyc = w + 2; wr_q.push_back(wv);
        done_q.push_back(w + 3);
        tick();
        rot_valid = 1'b0; rot_p = '0; rot_q = '0;
        repeat (4) tick();
        chk("busy after op", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [ROW_W-1:0] ra, rb, rc, rd, re, rf, rg, rh, rx, ry;
        int c0;
        rd_t r;
        ra = mk(32'ha0); rb = mk(32'hb1); rc = mk(32'hc2); rd = mk(32'hd3); re = mk(32'he4);
        rf = mk(32'hf5); rg = mk(32'h16); rh = mk(32'h27); rx = mk(32'h38); ry = mk(32'h49);

        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;

        // Basic pair, rows_ready already high.
        preload(5'd3, ra);
        preload(5'd7, rb);
        tick();
        run_op(5'd3, 5'd7, ra, rb, rc, rd, 0, 0, 0);
        chk_row("readback row3", mem[3], rc);
        chk_row("readback row7", mem[7], rd);

        // Backpressure on rows, delayed rot, and start pokes while busy.
        run_op(5'd7, 5'd3, rd, rc, re, rf, 4, 2, 1);
        chk_row("readback row7 b", mem[7], re);
        chk_row("readback row3 b", mem[3], rf);

        // Reset during WT_Q.
        preload(5'd20, rg);
        preload(5'd21, rh);
        c0 = cyc;
        r.addr = 5'd20; r.cyc = c0 + 1; rd_q.push_back(r);
        r.addr = 5'd21; r.cyc = c0 + 3; rd_q.push_back(r);
        p_idx = 5'd20; q_idx = 5'd21; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_zero("mid reset");
        reset = 1'b0;
        tick();
        chk_row("row20 untouched", mem[20], rg);

        // Boundary rows 31 and 0.
        preload(5'd31, rx);
        preload(5'd0, ry);
        tick();
        run_op(5'd31, 5'd0, rx, ry, rb, ra, 1, 0, 0);
        chk_row("readback row31", mem[31], rb);
        chk_row("readback row0", mem[0], ra);

        // Equal indices.
        preload(5'd9, re);
        tick();
`ifdef JACOBI_PAIR_CHECK_EN
        err_q.push_back(cyc + 1);
        p_idx = 5'd9; q_idx = 5'd9; start = 1'b1;
        tick();
        start = 1'b0;
        chk("pair busy", 64'(busy), 64'd0);
        repeat (6) tick();
        chk_row("row9 untouched", mem[9], re);
`else
        run_op(5'd9, 5'd9, re, re, rc, rd, 0, 1, 0);
        chk_row("readback row9", mem[9], rd);
`endif

        repeat (8) tick();
        chk("reads left", 64'(rd_q.size()), 64'd0);
        chk("rows left", 64'(rows_q.size()), 64'd0);
        chk("writes left", 64'(wr_q.size()), 64'd0);
        chk("dones left", 64'(done_q.size()), 64'd0);
        chk("errs left", 64'(err_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
